// File: rtl/usb_stream_writer.sv
// usb_stream_writer: drains 10-bit samples from the show-ahead sample FIFO and
// writes them as 16-bit words onto the FX3 slave-FIFO (GPIF) bus in fixed-size
// bursts, paced by the FX3 watermark flag. A test mode substitutes a free-running
// 10-bit counter for the FIFO data.
module usb_stream_writer #(
    parameter int BURST_WORDS = 8192,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        collectEnable,
    input  logic        testMode,
    input  logic [9:0]  fifoData,
    input  logic        fifoEmpty,
    input  logic        fifoHalfFull,
    output logic        fifoAck,
    input  logic        fx3Ready,
    output logic [15:0] fx3Data,
    output logic        fx3nWrite,
    output logic        underrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [13:0] LAST_WORD = 14'(BURST_WORDS - 1);
    localparam logic [3:0]  LAST_GAP  = 4'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [13:0] r_wordCount;
    logic [3:0]  r_gapCount;
    logic [9:0]  r_testCounter;
    logic [15:0] r_fx3Data;
    logic        r_fx3nWrite;
    logic        r_underrun;

    logic        w_write;
    logic        w_lastWord;
    logic        w_gapDone;
    logic        w_stall;
    logic        w_startBurst;
    logic        w_enterWait;

    assign fx3Data   = r_fx3Data;
    assign fx3nWrite = r_fx3nWrite;
    assign underrun  = r_underrun;

    // Write qualification, pop strobe and the state-transition helpers.
    always_comb begin
        w_write      = (r_state == BURST) && collectEnable && (testMode || !fifoEmpty);
        w_stall      = (r_state == BURST) && collectEnable && !testMode && fifoEmpty;
        fifoAck      = nReset && w_write && !testMode;
        w_lastWord   = (r_wordCount == LAST_WORD);
        w_gapDone    = (r_gapCount == LAST_GAP);
        w_startBurst = (r_state == WAIT) && (w_nextState == BURST);
        w_enterWait  = (r_state == IDLE) && (w_nextState == WAIT);
    end

    // Next-state logic; dropping collectEnable returns to IDLE from anywhere.
    always_comb begin
        w_nextState = r_state;
        if (!collectEnable) begin
            w_nextState = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    w_nextState = WAIT;
                WAIT:    if (fx3Ready && (testMode || fifoHalfFull)) w_nextState = BURST;
                BURST:   if (w_write && w_lastWord) w_nextState = GAP;
                GAP:     if (w_gapDone) w_nextState = WAIT;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // State, counters, registered bus outputs and the sticky underrun flag.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_state       <= IDLE;
            r_wordCount   <= 14'd0;
            r_gapCount    <= 4'd0;
            r_testCounter <= 10'd0;
            r_fx3Data     <= 16'h0000;
            r_fx3nWrite   <= 1'b1;
            r_underrun    <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_startBurst) begin
                r_wordCount <= 14'd0;
            end else if (w_write) begin
                r_wordCount <= w_lastWord ? 14'd0 : r_wordCount + 14'd1;
            end

            if ((r_state == GAP) && collectEnable && !w_gapDone) begin
                r_gapCount <= r_gapCount + 4'd1;
            end else begin
                r_gapCount <= 4'd0;
            end

            if (w_write && testMode) begin
                r_testCounter <= r_testCounter + 10'd1;
            end

            r_fx3nWrite <= !w_write;
            if (w_write) begin
                r_fx3Data <= testMode ? {6'b0, r_testCounter} : {6'b0, fifoData};
            end

            if (w_enterWait) begin
                r_underrun <= 1'b0;
            end else if (w_stall) begin
                r_underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_stream_writer.sv
// tb_usb_stream_writer: table-driven single-cycle vectors, directed multi-cycle
// sequences and a randomized run against a queue-based FIFO/bus scoreboard.
module tb_usb_stream_writer;

    localparam int BW  = 8;
    localparam int GAP = 4;

    logic        clock;
    logic        nReset;
    logic        collectEnable;
    logic        testMode;
    logic [9:0]  fifoData;
    logic        fifoEmpty;
    logic        fifoHalfFull;
    logic        fifoAck;
    logic        fx3Ready;
    logic [15:0] fx3Data;
    logic        fx3nWrite;
    logic        underrun;

    usb_stream_writer #(
        .BURST_WORDS(BW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock        (clock),
        .nReset       (nReset),
        .collectEnable(collectEnable),
        .testMode     (testMode),
        .fifoData     (fifoData),
        .fifoEmpty    (fifoEmpty),
        .fifoHalfFull (fifoHalfFull),
        .fifoAck      (fifoAck),
        .fx3Ready     (fx3Ready),
        .fx3Data      (fx3Data),
        .fx3nWrite    (fx3nWrite),
        .underrun     (underrun)
    );

    typedef struct {
        logic        n;
        logic        ce;
        logic        tm;
        logic        fe;
        logic        hf;
        logic        rdy;
        logic [9:0]  d;
        logic        expAck;
        logic        expNWrite;
        logic [15:0] expData;
        logic        expUnderrun;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;

    logic [9:0]  fifoQ[$];
    logic [9:0]  expQ[$];
    int          strobeCycles[$];
    logic [9:0]  tcModel;
    int          strobeCount;
    int          ackCount;
    int          forceLeft;
    int          cycleNo;
    int          lastStrobe;
    logic        checkGaps;
    logic [15:0] lastData;

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something wedges the main sequence.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic n, input logic ce, input logic tm, input logic fe,
                                input logic hf, input logic rdy, input logic [9:0] d,
                                input logic ack, input logic nw, input logic [15:0] data,
                                input logic und);
        vec_t v;
        v.n = n; v.ce = ce; v.tm = tm; v.fe = fe; v.hf = hf; v.rdy = rdy; v.d = d;
        v.expAck = ack; v.expNWrite = nw; v.expData = data; v.expUnderrun = und;
        return v;
    endfunction

    // One table vector: drive, check the combinational pop strobe, clock, check outputs.
    task automatic applyStimulus(input vec_t v, input int idx);
        nReset = v.n; collectEnable = v.ce; testMode = v.tm; fifoEmpty = v.fe;
        fifoHalfFull = v.hf; fx3Ready = v.rdy; fifoData = v.d;
        #1;
        checkOutput($sformatf("vec%0d fifoAck", idx), 32'(fifoAck), 32'(v.expAck));
        @(posedge clock);
        #1;
        checkOutput($sformatf("vec%0d fx3nWrite", idx), 32'(fx3nWrite), 32'(v.expNWrite));
        checkOutput($sformatf("vec%0d fx3Data", idx), 32'(fx3Data), 32'(v.expData));
        checkOutput($sformatf("vec%0d underrun", idx), 32'(underrun), 32'(v.expUnderrun));
    endtask

    // Three-cycle reset with the FIFO claiming data; clears the bench models.
    task automatic doReset();
        nReset = 1'b0; collectEnable = 1'b1; testMode = 1'b0; fifoEmpty = 1'b0;
        fifoHalfFull = 1'b1; fx3Ready = 1'b1; fifoData = 10'h155;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset fifoAck", 32'(fifoAck), 32'd0);
        checkOutput("reset fx3nWrite", 32'(fx3nWrite), 32'd1);
        checkOutput("reset fx3Data", 32'(fx3Data), 32'd0);
        checkOutput("reset underrun", 32'(underrun), 32'd0);
        fifoQ.delete(); expQ.delete(); strobeCycles.delete();
        tcModel = 10'd0; strobeCount = 0; ackCount = 0; forceLeft = 0;
        cycleNo = 0; lastStrobe = 0; checkGaps = 1'b1;
        collectEnable = 1'b0; fx3Ready = 1'b0;
        nReset = 1'b1;
    endtask

    // One clock of the FIFO model plus bus scoreboard.
    task automatic runCycle();
        logic       ackNow;
        logic       tmNow;
        logic       haveExp;
        logic [9:0] expWord;
        fifoEmpty    = (fifoQ.size() == 0) || (forceLeft > 0);
        fifoData     = (fifoQ.size() != 0) ? fifoQ[0] : 10'h000;
        fifoHalfFull = (fifoQ.size() >= BW);
        #1;
        ackNow = fifoAck;
        tmNow  = testMode;
        vectors++;
        if (ackNow && (fifoEmpty || tmNow)) begin
            miscompares++;
            $display("[TB] FAIL ackLegal: fifoAck=1 with fifoEmpty=%0b testMode=%0b, required 0",
                     fifoEmpty, tmNow);
        end
        @(posedge clock);
        if (ackNow) begin
            ackCount++;
            if (fifoQ.size() != 0) expQ.push_back(fifoQ.pop_front());
        end
        if (forceLeft > 0) forceLeft--;
        #1;
        cycleNo++;
        if (fx3nWrite == 1'b0) begin
            if (checkGaps && strobeCount != 0 && (strobeCount % BW) == 0) begin
                checkOutput("burstGap>=GAP", 32'((cycleNo - lastStrobe - 1) >= GAP), 32'd1);
            end
            haveExp = 1'b1;
            expWord = 10'h000;
            if (tmNow) begin
                expWord = tcModel;
                tcModel = tcModel + 10'd1;
            end else if (expQ.size() != 0) begin
                expWord = expQ.pop_front();
            end else begin
                haveExp = 1'b0;
            end
            if (haveExp) begin
                checkOutput("strobeData", 32'(fx3Data), {22'b0, expWord});
            end else begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL strobeSource: write of 0x%0h with no popped word, required no write",
                         fx3Data);
            end
            lastData = fx3Data;
            strobeCycles.push_back(cycleNo);
            lastStrobe = cycleNo;
            strobeCount++;
        end
    endtask

    vec_t table_v[14];
    int   budget;
    logic forcedOnce;

    initial begin
        // Reset, WAIT with/without fx3Ready, mode switch, stall, disable, re-enable.
        table_v[0]  = mk(0,1,0,0,1,1,10'h155, 0,1,16'h0000,0);
        table_v[1]  = mk(0,1,0,0,1,1,10'h155, 0,1,16'h0000,0);
        table_v[2]  = mk(0,1,0,0,1,1,10'h155, 0,1,16'h0000,0);
        table_v[3]  = mk(1,1,0,0,1,0,10'h155, 0,1,16'h0000,0);
        table_v[4]  = mk(1,1,0,0,1,0,10'h155, 0,1,16'h0000,0);
        table_v[5]  = mk(1,1,0,0,1,0,10'h155, 0,1,16'h0000,0);
        table_v[6]  = mk(1,1,0,0,1,1,10'h155, 0,1,16'h0000,0);
        table_v[7]  = mk(1,1,0,0,1,0,10'h2AA, 1,0,16'h02AA,0);
        table_v[8]  = mk(1,1,1,0,1,0,10'h3FF, 0,0,16'h0000,0);
        table_v[9]  = mk(1,1,1,1,0,0,10'h3FF, 0,0,16'h0001,0);
        table_v[10] = mk(1,1,0,1,0,0,10'h3FF, 0,1,16'h0001,1);
        table_v[11] = mk(1,0,0,0,1,0,10'h111, 0,1,16'h0001,1);
        table_v[12] = mk(1,1,0,0,1,0,10'h111, 0,1,16'h0001,0);
        table_v[13] = mk(0,1,0,0,1,1,10'h111, 0,1,16'h0000,0);
        for (int i = 0; i < 14; i++) applyStimulus(table_v[i], i);

        // Two back-to-back bursts from a preloaded FIFO.
        doReset();
        for (int i = 1; i <= 16; i++) fifoQ.push_back(10'(i));
        collectEnable = 1'b1; fx3Ready = 1'b1;
        budget = 0;
        while (strobeCount < 16 && budget < 200) begin runCycle(); budget++; end
        checkOutput("t2 strobeCount", 32'(strobeCount), 32'd16);
        if (strobeCount >= 16) begin
            checkOutput("t2 burst1 contiguous", 32'(strobeCycles[7] - strobeCycles[0]), 32'd7);
            checkOutput("t2 burst2 contiguous", 32'(strobeCycles[15] - strobeCycles[8]), 32'd7);
            // GAP idle cycles plus the single WAIT cycle before the next burst.
            checkOutput("t2 gap window",
                        32'((strobeCycles[8] - strobeCycles[7] - 1) >= GAP &&
                            (strobeCycles[8] - strobeCycles[7] - 1) <= GAP + 1), 32'd1);
        end
        checkOutput("t2 last word", 32'(lastData), 32'h0010);

        // FIFO empties for 5 cycles after the 3rd pop of an 8-word burst.
        doReset();
        for (int i = 0; i < 8; i++) fifoQ.push_back(10'(32'h21 + i));
        collectEnable = 1'b1; fx3Ready = 1'b1;
        forcedOnce = 1'b0; budget = 0;
        while (strobeCount < 8 && budget < 200) begin
            runCycle();
            budget++;
            if (ackCount == 3 && !forcedOnce) begin
                checkOutput("t3 underrun before stall", 32'(underrun), 32'd0);
                forceLeft = 5;
                forcedOnce = 1'b1;
            end
        end
        checkOutput("t3 strobeCount", 32'(strobeCount), 32'd8);
        checkOutput("t3 underrun", 32'(underrun), 32'd1);
        if (strobeCount >= 8) begin
            checkOutput("t3 stall length", 32'(strobeCycles[3] - strobeCycles[2] - 1), 32'd5);
            checkOutput("t3 tail contiguous", 32'(strobeCycles[7] - strobeCycles[3]), 32'd4);
        end

        // Test counter wrap across 1023 -> 0 without touching the FIFO.
        doReset();
        testMode = 1'b1; collectEnable = 1'b1; fx3Ready = 1'b1;
        budget = 0;
        while (strobeCount < 1020 && budget < 4000) begin runCycle(); budget++; end
        checkOutput("t4 pre-wrap data", 32'(lastData), 32'd1019);
        budget = 0;
        while (strobeCount < 1028 && budget < 100) begin runCycle(); budget++; end
        checkOutput("t4 post-wrap data", 32'(lastData), 32'd3);
        checkOutput("t4 no pops", 32'(ackCount), 32'd0);

        // Disable after the 4th write, then re-enable for a clean full burst.
        doReset();
        checkGaps = 1'b0;
        for (int i = 1; i <= 16; i++) fifoQ.push_back(10'(i));
        collectEnable = 1'b1; fx3Ready = 1'b1;
        forcedOnce = 1'b0; budget = 0;
        while (ackCount < 4 && budget < 200) begin
            runCycle();
            budget++;
            if (ackCount == 2 && !forcedOnce) begin
                forceLeft = 1;
                forcedOnce = 1'b1;
            end
        end
        collectEnable = 1'b0;
        repeat (6) runCycle();
        checkOutput("t5 writes before disable", 32'(strobeCount), 32'd4);
        checkOutput("t5 underrun held", 32'(underrun), 32'd1);
        collectEnable = 1'b1;
        runCycle();
        checkOutput("t5 underrun cleared", 32'(underrun), 32'd0);
        budget = 0;
        while (strobeCount < 12 && budget < 200) begin runCycle(); budget++; end
        checkOutput("t5 strobeCount", 32'(strobeCount), 32'd12);
        if (strobeCount >= 12) begin
            checkOutput("t5 full burst contiguous", 32'(strobeCycles[11] - strobeCycles[4]), 32'd7);
        end
        checkOutput("t5 last word", 32'(lastData), 32'h000C);

        // Randomized traffic: FIFO fill, empties, fx3Ready and mode switches.
        doReset();
        collectEnable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) != 0 && fifoQ.size() < 40) fifoQ.push_back(10'($urandom));
            if (forceLeft == 0 && $urandom_range(0, 19) == 0) forceLeft = int'($urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) testMode = ~testMode;
            fx3Ready = ($urandom_range(0, 9) < 7);
            runCycle();
        end
        checkOutput("rand made progress", 32'(strobeCount > BW), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
